seq_controller: RTL and testbench

Multi-cycle phase sequencer for the Y86-64 SEQ processor. It owns the architectural PC and status register and drives one-hot enables for fetch, decode, execute, memory and writeback, one phase per clock. It selects the next PC from fetch, execute and memory results and stops on halt, invalid instruction or memory error. It sits above the fetch, decode and execute blocks and replaces bench-driven PC/clock stepping.

---
 rtl/y86_pkg.sv | 52 +++++
 rtl/seq_pc_select.sv | 25 ++
 rtl/seq_controller.sv | 202 ++++++++++++++++++++
 tb/tb_seq_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// SEQ controller state encoding.
// Optional feature macro: SEQ_CTRL_STEP_EN (adds the PAUSE state).
package y86_pkg;

    // Instruction codes (icode field)
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Processor status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Controller phase states
`ifdef SEQ_CTRL_STEP_EN
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_STOPPED,
        S_PAUSE
    } ctrl_state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_STOPPED
    } ctrl_state_t;
`endif

endpackage

// File: rtl/seq_pc_select.sv
// Combinational next-PC selection for the SEQ processor.
module seq_pc_select
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    output logic [63:0] new_pc
);

    // Pick call/taken-jump target, return address, or fall-through PC
    always_comb begin
        new_pc = valP;
        if (icode == I_CALL) begin
            new_pc = valC;
        end else if (icode == I_JXX && cnd) begin
            new_pc = valC;
        end else if (icode == I_RET) begin
            new_pc = valM;
        end
    end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle phase sequencer for the Y86-64 SEQ processor. Owns the
// architectural PC and status, drives one-hot phase enables and stops on
// halt, invalid instruction or memory error.
// Optional feature macro: SEQ_CTRL_STEP_EN (single-step via PAUSE state).
module seq_controller
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned CNT_W    = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SEQ_CTRL_STEP_EN
    input  logic             step,
`endif
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             invalid_instr,
    input  logic             halt,
    input  logic             cnd,
    input  logic             dmem_error,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic [63:0]      valM,
    output logic [63:0]      PC,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic [2:0]       r_stat;
    logic [2:0]       w_next_stat;

    logic [63:0]      r_pc;
    logic [3:0]       r_icode;
    logic [63:0]      r_valC;
    logic [63:0]      r_valP;
    logic [63:0]      r_valM;
    logic             r_cnd;
    logic [63:0]      w_new_pc;

    logic             r_fetch_en;
    logic             r_decode_en;
    logic             r_execute_en;
    logic             r_mem_en;
    logic             r_wb_en;
    logic             r_halted;

    logic [CNT_W-1:0] r_instr_count;
    logic [CNT_W-1:0] r_cycle_count;
    logic             w_phase_active;

    // Next-state and stop-status decision
    always_comb begin
        w_next_state = r_state;
        w_next_stat  = r_stat;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (imem_error) begin
                    w_next_state = S_STOPPED;
                    w_next_stat  = STAT_ADR;
                end else if (invalid_instr) begin
                    w_next_state = S_STOPPED;
                    w_next_stat  = STAT_INS;
                end else if (halt) begin
                    w_next_state = S_STOPPED;
                    w_next_stat  = STAT_HLT;
                end else begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE:  w_next_state = S_EXECUTE;
            S_EXECUTE: w_next_state = S_MEMORY;
            S_MEMORY: begin
                if (dmem_error) begin
                    w_next_state = S_STOPPED;
                    w_next_stat  = STAT_ADR;
                end else begin
                    w_next_state = S_WRITEBACK;
                end
            end
            S_WRITEBACK: w_next_state = S_PCUPD;
`ifdef SEQ_CTRL_STEP_EN
            S_PCUPD: w_next_state = S_PAUSE;
            S_PAUSE: begin
                if (step) w_next_state = S_FETCH;
            end
`else
            S_PCUPD: w_next_state = S_FETCH;
`endif
            S_STOPPED: w_next_state = S_STOPPED;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State, status and registered phase enables (decoded from next state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_stat       <= STAT_AOK;
            r_fetch_en   <= 1'b0;
            r_decode_en  <= 1'b0;
            r_execute_en <= 1'b0;
            r_mem_en     <= 1'b0;
            r_wb_en      <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_stat       <= w_next_stat;
            r_fetch_en   <= (w_next_state == S_FETCH);
            r_decode_en  <= (w_next_state == S_DECODE);
            r_execute_en <= (w_next_state == S_EXECUTE);
            r_mem_en     <= (w_next_state == S_MEMORY);
            r_wb_en      <= (w_next_state == S_WRITEBACK);
            r_halted     <= (w_next_state == S_STOPPED);
        end
    end

    // Capture stage results at the end of the phase that produces them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_icode <= '0;
            r_valC  <= '0;
            r_valP  <= '0;
            r_valM  <= '0;
            r_cnd   <= 1'b0;
        end else begin
            if (r_state == S_FETCH) begin
                r_icode <= icode;
                r_valC  <= valC;
                r_valP  <= valP;
            end
            if (r_state == S_EXECUTE) r_cnd  <= cnd;
            if (r_state == S_MEMORY)  r_valM <= valM;
        end
    end

    seq_pc_select u_pc_select (
        .icode  (r_icode),
        .cnd    (r_cnd),
        .valC   (r_valC),
        .valP   (r_valP),
        .valM   (r_valM),
        .new_pc (w_new_pc)
    );

    // Architectural PC update at the end of PCUPD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (r_state == S_PCUPD) begin
            r_pc <= w_new_pc;
        end
    end

`ifdef SEQ_CTRL_STEP_EN
    assign w_phase_active = (r_state != S_IDLE) && (r_state != S_STOPPED) &&
                            (r_state != S_PAUSE);
`else
    assign w_phase_active = (r_state != S_IDLE) && (r_state != S_STOPPED);
`endif

    // Saturating retired-instruction and active-cycle counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
            r_cycle_count <= '0;
        end else begin
            if (r_state == S_PCUPD && r_instr_count != '1) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
            if (w_phase_active && r_cycle_count != '1) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
        end
    end

    assign PC          = r_pc;
    assign stat        = r_stat;
    assign halted      = r_halted;
    assign fetch_en    = r_fetch_en;
    assign decode_en   = r_decode_en;
    assign execute_en  = r_execute_en;
    assign mem_en      = r_mem_en;
    assign wb_en       = r_wb_en;
    assign instr_count = r_instr_count;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_seq_controller.sv
// Directed self-checking bench for seq_controller (default build).
module tb_seq_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        step;
    logic [3:0]  icode;
    logic        imem_error;
    logic        invalid_instr;
    logic        halt;
    logic        cnd;
    logic        dmem_error;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valM;
    logic [63:0] PC;
    logic        fetch_en, decode_en, execute_en, mem_en, wb_en;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] instr_count;
    logic [31:0] cycle_count;
    logic [4:0]  en;

    int unsigned total;
    int unsigned bad;
    logic        wb_seen;

    seq_controller #(
        .RESET_PC (64'd0),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
`ifdef SEQ_CTRL_STEP_EN
        .step          (step),
`endif
        .icode         (icode),
        .imem_error    (imem_error),
        .invalid_instr (invalid_instr),
        .halt          (halt),
        .cnd           (cnd),
        .dmem_error    (dmem_error),
        .valC          (valC),
        .valP          (valP),
        .valM          (valM),
        .PC            (PC),
        .fetch_en      (fetch_en),
        .decode_en     (decode_en),
        .execute_en    (execute_en),
        .mem_en        (mem_en),
        .wb_en         (wb_en),
        .stat          (stat),
        .halted        (halted),
        .instr_count   (instr_count),
        .cycle_count   (cycle_count)
    );

    assign en = {fetch_en, decode_en, execute_en, mem_en, wb_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wb_en) wb_seen = 1'b1;
    endtask

    task automatic clear_inputs();
        start         = 1'b0;
        step          = 1'b1;
        icode         = 4'h1;
        imem_error    = 1'b0;
        invalid_instr = 1'b0;
        halt          = 1'b0;
        cnd           = 1'b0;
        dmem_error    = 1'b0;
        valC          = '0;
        valP          = '0;
        valM          = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // From IDLE, pulse start and land in FETCH
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called while in FETCH; runs one full 6-cycle instruction
    task automatic do_instr(input logic [3:0] ic, input logic [63:0] c,
                            input logic [63:0] p, input logic [63:0] m,
                            input logic cn);
        icode = ic; valC = c; valP = p; valM = m; cnd = cn;
        for (int i = 0; i < 6; i++) tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        wb_seen = 1'b0;
        clear_inputs();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_pc", PC, 64'd0);
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_icnt", 64'(instr_count), 64'd0);
        chk("rst_ccnt", 64'(cycle_count), 64'd0);

        // irmovq at PC 0, valP=10: walk the enables
        icode = 4'h3; valP = 64'd10;
        go();
        chk("ph_fetch", 64'(en), 64'b10000);
        tick(); chk("ph_decode", 64'(en), 64'b01000);
        tick(); chk("ph_execute", 64'(en), 64'b00100);
        tick(); chk("ph_memory", 64'(en), 64'b00010);
        tick(); chk("ph_wb", 64'(en), 64'b00001);
        tick(); chk("ph_pcupd", 64'(en), 64'b00000);
        chk("pc_before_upd", PC, 64'd0);
        tick(); chk("ph_fetch2", 64'(en), 64'b10000);
        chk("irmov_pc", PC, 64'd10);
        chk("irmov_icnt", 64'(instr_count), 64'd1);
        chk("irmov_ccnt", 64'(cycle_count), 64'd6);

        // jXX taken / not taken, call, ret
        do_instr(4'h7, 64'h40, 64'd9, 64'd0, 1'b1);
        chk("jxx_taken_pc", PC, 64'h40);
        do_instr(4'h7, 64'h40, 64'd9, 64'd0, 1'b0);
        chk("jxx_nt_pc", PC, 64'd9);
        do_instr(4'h8, 64'h200, 64'd18, 64'd0, 1'b0);
        chk("call_pc", PC, 64'h200);
        do_instr(4'h9, 64'h0, 64'h201, 64'h100, 1'b0);
        chk("ret_pc", PC, 64'h100);
        chk("ret_icnt", 64'(instr_count), 64'd5);
        chk("ret_ccnt", 64'(cycle_count), 64'd30);

        // dmem_error in MEMORY
        icode = 4'h5; valP = 64'h10a; dmem_error = 1'b1;
        wb_seen = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("dmem_halted", 64'(halted), 64'd1);
        chk("dmem_stat", 64'(stat), 64'd3);
        chk("dmem_pc", PC, 64'h100);
        chk("dmem_icnt", 64'(instr_count), 64'd5);
        for (int i = 0; i < 3; i++) tick();
        chk("dmem_no_wb", 64'(wb_seen), 64'd0);
        chk("dmem_en", 64'(en), 64'd0);
        chk("dmem_ccnt", 64'(cycle_count), 64'd34);

        // Halt at PC 0x14
        do_reset();
        go();
        do_instr(4'h1, 64'd0, 64'h14, 64'd0, 1'b0);
        chk("nop_pc", PC, 64'h14);
        icode = 4'h0; halt = 1'b1;
        tick();
        chk("halt_stat", 64'(stat), 64'd2);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_pc", PC, 64'h14);
        chk("halt_icnt", 64'(instr_count), 64'd1);

        // Invalid instruction at PC 0x30 (invalid beats halt)
        do_reset();
        go();
        do_instr(4'h7, 64'h30, 64'd9, 64'd0, 1'b1);
        chk("jmp30_pc", PC, 64'h30);
        icode = 4'hF; invalid_instr = 1'b1; halt = 1'b1;
        tick();
        chk("ins_stat", 64'(stat), 64'd4);
        chk("ins_halted", 64'(halted), 64'd1);
        chk("ins_pc", PC, 64'h30);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ins_stuck_en", 64'(en), 64'd0);
        end
        start = 1'b0;
        chk("ins_stuck_halted", 64'(halted), 64'd1);

        // imem_error beats everything
        do_reset();
        go();
        imem_error = 1'b1; invalid_instr = 1'b1; halt = 1'b1;
        tick();
        chk("imem_stat", 64'(stat), 64'd3);
        chk("imem_pc", PC, 64'd0);

        // Reset asserted during EXECUTE
        do_reset();
        go();
        do_instr(4'h3, 64'd0, 64'd10, 64'd0, 1'b0);
        icode = 4'h6; valP = 64'd12;
        tick(); tick();
        chk("pre_rst_exec", 64'(en), 64'b00100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_en", 64'(en), 64'd0);
        chk("async_pc", PC, 64'd0);
        chk("async_icnt", 64'(instr_count), 64'd0);
        chk("async_ccnt", 64'(cycle_count), 64'd0);
        chk("async_stat", 64'(stat), 64'd1);
        tick();
        rst_n = 1'b1;
        clear_inputs();
        tick();
        chk("idle_en", 64'(en), 64'd0);
        go();
        chk("restart_fetch", 64'(en), 64'b10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
